// File: rtl/rf_frame_receiver_if.sv
// ----------------------------------------------------------------------------
// rf_frame_receiver_if
//   Bundles the decoded-bit input stream and the frame-layer outputs of
//   rf_frame_receiver.
//   master : the side feeding decoded bits (decoder / testbench)
//   slave  : the frame receiver itself
// Signals
//   enable      master->slave  block enable
//   bit_stb     master->slave  one-cycle strobe, din/error carry a new bit
//   din         master->slave  decoded data bit
//   error       master->slave  Manchester violation for this bit
//   byte_out    slave->master  last completed payload byte
//   byte_valid  slave->master  one-cycle pulse, new payload byte
//   frame_ok    slave->master  one-cycle pulse, check byte matched
//   frame_err   slave->master  one-cycle pulse, frame aborted or bad check
//   busy        slave->master  high while a frame is being received
// ----------------------------------------------------------------------------
interface rf_frame_receiver_if;
    logic       enable;
    logic       bit_stb;
    logic       din;
    logic       error;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;

    modport master (
        output enable, bit_stb, din, error,
        input  byte_out, byte_valid, frame_ok, frame_err, busy
    );

    modport slave (
        input  enable, bit_stb, din, error,
        output byte_out, byte_valid, frame_ok, frame_err, busy
    );
endinterface

// File: rtl/rf_frame_receiver.sv
// ----------------------------------------------------------------------------
// rf_frame_receiver
//   Frame layer behind the Manchester decoder. Hunts for a 16-bit sync word in
//   the strobed bit stream, then receives a length byte, LEN payload bytes and
//   a check byte. Payload bytes are emitted with a one-cycle strobe and every
//   frame ends with a frame_ok or frame_err pulse.
// Parameters
//   SYNC_WORD  sync pattern, MSB first
//   MAX_LEN    largest accepted length byte (1..255)
// Ports
//   clk2x      system clock
//   rst_n      asynchronous active-low reset
//   bus        rf_frame_receiver_if.slave (enable, bit_stb, din, error in;
//              byte_out, byte_valid, frame_ok, frame_err, busy out)
// Configuration
//   CRC8_EN    defined  : check byte is CRC-8 (poly 0x07, init 0x00, no
//                         reflection, no final XOR), updated bit by bit
//              undefined: check byte is the 8-bit sum of length and payload
// ----------------------------------------------------------------------------
module rf_frame_receiver #(
    parameter logic [15:0] SYNC_WORD = 16'h2DD4,
    parameter int unsigned MAX_LEN   = 32
) (
    input  logic               clk2x,
    input  logic               rst_n,
    rf_frame_receiver_if.slave bus
);
    localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

    typedef enum logic [1:0] {HUNT, LEN, DATA, CHK} state_t;

    state_t      state_q;
    logic [15:0] shift_q;
    logic [15:0] shift_d;
    logic [2:0]  bitcnt_q;
    logic [7:0]  acc_q;
    logic [7:0]  acc_d;
    logic [7:0]  rem_q;
    logic [7:0]  csum_q;
    logic [7:0]  csum_d;
    logic [7:0]  byte_out_q;
    logic        byte_valid_q;
    logic        frame_ok_q;
    logic        frame_err_q;
    logic        byte_done;

    always_comb begin
        shift_d   = {shift_q[14:0], bus.din};
        acc_d     = {acc_q[6:0], bus.din};
        byte_done = (bitcnt_q == 3'd7);
`ifdef CRC8_EN
        // MSB-first CRC-8 step for the incoming bit.
        csum_d = {csum_q[6:0], 1'b0} ^ ((csum_q[7] ^ bus.din) ? 8'h07 : 8'h00);
`else
        // Modular sum only advances once a whole byte has been assembled.
        csum_d = byte_done ? (csum_q + acc_d) : csum_q;
`endif
    end

    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            acc_q        <= '0;
            rem_q        <= '0;
            csum_q       <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;

            if (!bus.enable) begin
                // Silent drop: no frame_err for an interrupted frame.
                state_q <= HUNT;
                shift_q <= '0;
            end else if (bus.bit_stb) begin
                case (state_q)
                    HUNT: begin
                        if (bus.error) begin
                            shift_q <= '0;
                        end else if (shift_d == SYNC_WORD) begin
                            // Clear the hunt register so the next frame needs
                            // a complete fresh sync word.
                            state_q  <= LEN;
                            shift_q  <= '0;
                            bitcnt_q <= '0;
                            csum_q   <= '0;
                        end else begin
                            shift_q <= shift_d;
                        end
                    end
                    default: begin
                        if (bus.error) begin
                            frame_err_q <= 1'b1;
                            state_q     <= HUNT;
                        end else begin
                            acc_q    <= acc_d;
                            bitcnt_q <= bitcnt_q + 3'd1;
                            // The check byte itself is not part of the checksum.
                            if (state_q != CHK) begin
                                csum_q <= csum_d;
                            end
                            if (byte_done) begin
                                if (state_q == LEN) begin
                                    if (acc_d == 8'd0) begin
                                        state_q <= CHK;
                                    end else if (acc_d <= MAX_LEN_B) begin
                                        state_q <= DATA;
                                        rem_q   <= acc_d;
                                    end else begin
                                        frame_err_q <= 1'b1;
                                        state_q     <= HUNT;
                                    end
                                end else if (state_q == DATA) begin
                                    byte_out_q   <= acc_d;
                                    byte_valid_q <= 1'b1;
                                    rem_q        <= rem_q - 8'd1;
                                    if (rem_q == 8'd1) begin
                                        state_q <= CHK;
                                    end
                                end else begin
                                    if (acc_d == csum_q) begin
                                        frame_ok_q <= 1'b1;
                                    end else begin
                                        frame_err_q <= 1'b1;
                                    end
                                    state_q <= HUNT;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != HUNT);
endmodule

// File: tb/tb_rf_frame_receiver.sv
// ----------------------------------------------------------------------------
// tb_rf_frame_receiver
//   Directed bench for rf_frame_receiver: bits are fed MSB first, one strobe
//   every other clk2x cycle, and outputs are sampled 1 ns after each edge.
// ----------------------------------------------------------------------------
module tb_rf_frame_receiver;
    logic clk2x = 1'b0;
    logic rst_n;

    rf_frame_receiver_if bus();

    rf_frame_receiver dut (
        .clk2x (clk2x),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk2x = ~clk2x;

    int tests = 0;
    int fails = 0;
    int nbv, nok, nerr, overlap;
    logic [7:0] got[$];
    logic lb_bv, lb_ok, lb_err;
    logic [7:0] chk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] got_at(input int idx);
        if (idx < got.size()) return got[idx];
        return 8'hxx;
    endfunction

`ifdef CRC8_EN
    function automatic logic [7:0] crc_add(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = {r[6:0], 1'b0} ^ ((r[7] ^ b[i]) ? 8'h07 : 8'h00);
        end
        return r;
    endfunction
`endif

    task automatic clear_counts();
        nbv = 0; nok = 0; nerr = 0; overlap = 0;
        got.delete();
    endtask

    // One clock; record any pulses. save=1 keeps the sample as "last bit" view.
    task automatic tick(input bit save);
        @(posedge clk2x); #1;
        if (save) begin
            lb_bv  = bus.byte_valid;
            lb_ok  = bus.frame_ok;
            lb_err = bus.frame_err;
        end
        if (bus.byte_valid) begin
            nbv++;
            got.push_back(bus.byte_out);
        end
        if (bus.frame_ok)  nok++;
        if (bus.frame_err) nerr++;
        if (int'(bus.byte_valid) + int'(bus.frame_ok) + int'(bus.frame_err) > 1) overlap++;
    endtask

    task automatic send_bit(input logic b, input logic e);
        bus.din     = b;
        bus.error   = e;
        bus.bit_stb = 1'b1;
        tick(1'b1);
        bus.bit_stb = 1'b0;
        bus.error   = 1'b0;
        tick(1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
    endtask

    task automatic send_sync();
        send_byte(8'h2D);
        send_byte(8'hD4);
    endtask

    initial begin
        logic [7:0] v;
        rst_n       = 1'b0;
        bus.enable  = 1'b1;
        bus.bit_stb = 1'b0;
        bus.din     = 1'b0;
        bus.error   = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk2x);
        #1;
        check("rst_busy",       bus.busy,       0);
        check("rst_byte_out",   bus.byte_out,   0);
        check("rst_byte_valid", bus.byte_valid, 0);
        check("rst_frame_ok",   bus.frame_ok,   0);
        check("rst_frame_err",  bus.frame_err,  0);
        rst_n = 1'b1;
        tick(1'b0);

        // 1: good frame 03 11 22 33
`ifdef CRC8_EN
        chk = crc_add(crc_add(crc_add(crc_add(8'h00, 8'h03), 8'h11), 8'h22), 8'h33);
`else
        chk = 8'h69;
`endif
        clear_counts();
        send_sync();
        check("t1_busy_sync", bus.busy, 1);
        send_byte(8'h03);
        send_byte(8'h11);
        check("t1_first_byte_pulse", lb_bv, 1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(chk);
        check("t1_ok_latency", lb_ok, 1);
        check("t1_nbv",  nbv, 3);
        check("t1_b0",   got_at(0), 8'h11);
        check("t1_b1",   got_at(1), 8'h22);
        check("t1_b2",   got_at(2), 8'h33);
        check("t1_nok",  nok, 1);
        check("t1_nerr", nerr, 0);
        check("t1_overlap", overlap, 0);
        check("t1_busy_end", bus.busy, 0);
        check("t1_byte_held", bus.byte_out, 8'h33);

        // 2: same frame with a wrong check byte
        clear_counts();
        send_sync();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(chk ^ 8'h01);
        check("t2_err_latency", lb_err, 1);
        check("t2_nbv",  nbv, 3);
        check("t2_nok",  nok, 0);
        check("t2_nerr", nerr, 1);
        check("t2_busy", bus.busy, 0);

        // 3: empty frames, good and bad check
        clear_counts();
        send_sync();
        send_byte(8'h00);
        send_byte(8'h00);
        check("t3_nbv", nbv, 0);
        check("t3_nok", nok, 1);
        check("t3_nerr", nerr, 0);
        clear_counts();
        send_sync();
        send_byte(8'h00);
        send_byte(8'h01);
        check("t3b_nok", nok, 0);
        check("t3b_nerr", nerr, 1);

        // 4: length 0x21 exceeds MAX_LEN, then a normal frame
        clear_counts();
        send_sync();
        send_byte(8'h21);
        check("t4_err_after_len", lb_err, 1);
        check("t4_nerr", nerr, 1);
        check("t4_busy", bus.busy, 0);
`ifdef CRC8_EN
        chk = crc_add(crc_add(8'h00, 8'h01), 8'hAA);
`else
        chk = 8'hAB;
`endif
        clear_counts();
        send_sync();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(chk);
        check("t4b_nbv", nbv, 1);
        check("t4b_b0",  got_at(0), 8'hAA);
        check("t4b_nok", nok, 1);
        check("t4b_nerr", nerr, 0);

        // 5: decoder error on 4th bit of the 2nd payload byte
        clear_counts();
        send_sync();
        send_byte(8'h03);
        send_byte(8'h11);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        check("t5_err_latency", lb_err, 1);
        check("t5_nbv",  nbv, 1);
        check("t5_b0",   got_at(0), 8'h11);
        check("t5_nerr", nerr, 1);
        check("t5_busy", bus.busy, 0);
        check("t5_byte_out", bus.byte_out, 8'h11);

        // 6: enable dropped mid-DATA, then sync with an error inside it
        clear_counts();
        send_sync();
        send_byte(8'h03);
        send_byte(8'h44);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        bus.enable = 1'b0;
        tick(1'b0);
        check("t6_busy_off", bus.busy, 0);
        send_byte(8'h55);
        send_byte(8'h66);
        check("t6_nbv",  nbv, 1);
        check("t6_nerr", nerr, 0);
        check("t6_nok",  nok, 0);
        check("t6_byte_held", bus.byte_out, 8'h44);
        bus.enable = 1'b1;
        tick(1'b0);
        clear_counts();
        send_byte(8'h2D);
        v = 8'hD4;
        for (int i = 7; i >= 0; i--) send_bit(v[i], (i == 4) ? 1'b1 : 1'b0);
        check("t6_no_sync_busy", bus.busy, 0);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t6_no_sync_nok", nok, 0);
        check("t6_no_sync_nerr", nerr, 0);
        clear_counts();
        send_sync();
        send_byte(8'h00);
        send_byte(8'h00);
        check("t6_recover_nok", nok, 1);
        check("t6_recover_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
